// File: rtl/traffic_light_controller.sv
// traffic_light_controller
//   Moore FSM driving the 7-bit lamp vector {Rm,Ym,Gm,Rs,Ys,Gs,Walk} of a
//   main/side road intersection. The main road rests on green. Latched
//   side-road and pedestrian requests are served in turn once main green has
//   run its minimum time. All phase timing counts the one-clock 'tick'
//   enable, so every T_* parameter is in ticks rather than clocks.
//
//   Optional feature macro: NIGHT_MODE_EN (flashing-yellow night mode).
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   tick     in   timebase enable, one clk wide
//   side_req in   side-road vehicle sensor (level or pulse)
//   walk_req in   pedestrian button (level or pulse)
//   night    in   night-mode request (only used with NIGHT_MODE_EN)
//   LEDs     out  [6]Rm [5]Ym [4]Gm [3]Rs [2]Ys [1]Gs [0]Walk
//   state    out  current state code (debug)
module traffic_light_controller #(
  parameter int T_MG_MIN = 10,
  parameter int T_MY     = 3,
  parameter int T_AR     = 1,
  parameter int T_SG     = 6,
  parameter int T_SY     = 3,
  parameter int T_WALK   = 5,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       side_req,
  input  logic       walk_req,
  input  logic       night,
  output logic [6:0] LEDs,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR1   = 3'd2,
    S_WALK  = 3'd3,
    S_SG    = 3'd4,
    S_SY    = 3'd5,
    S_AR2   = 3'd6,
    S_NIGHT = 3'd7
  } state_t;

  // Each timed phase ends on the tick where the counter holds its last value.
  localparam logic [CNT_W-1:0] MG_LAST   = CNT_W'(T_MG_MIN - 1);
  localparam logic [CNT_W-1:0] MY_LAST   = CNT_W'(T_MY - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_AR - 1);
  localparam logic [CNT_W-1:0] SG_LAST   = CNT_W'(T_SG - 1);
  localparam logic [CNT_W-1:0] SY_LAST   = CNT_W'(T_SY - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             side_pend_q, side_pend_d;
  logic             walk_pend_q, walk_pend_d;
  logic             timed;
  logic [CNT_W-1:0] phase_last;
  state_t           phase_next;

`ifdef NIGHT_MODE_EN
  logic             flash_q, flash_d;
`else
  logic             night_unused;
  assign night_unused = night;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_AR2;
      cnt_q       <= '0;
      side_pend_q <= 1'b0;
      walk_pend_q <= 1'b0;
`ifdef NIGHT_MODE_EN
      flash_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      side_pend_q <= side_pend_d;
      walk_pend_q <= walk_pend_d;
`ifdef NIGHT_MODE_EN
      flash_q     <= flash_d;
`endif
    end
  end

  // Next state and phase counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timed      = 1'b1;
    phase_last = '0;
    phase_next = state_q;
    case (state_q)
      S_MG:   timed = 1'b0;
      S_MY:   begin phase_last = MY_LAST;   phase_next = S_AR1; end
      S_AR1:  begin phase_last = AR_LAST;   phase_next = walk_pend_q ? S_WALK : S_SG; end
      S_WALK: begin phase_last = WALK_LAST; phase_next = side_pend_q ? S_SG : S_AR2; end
      S_SG:   begin phase_last = SG_LAST;   phase_next = S_SY; end
      S_SY:   begin phase_last = SY_LAST;   phase_next = S_AR2; end
      S_AR2:  begin phase_last = AR_LAST;   phase_next = S_MG; end
      default: begin
`ifdef NIGHT_MODE_EN
        timed = 1'b0;
`else
        // Code 7 cannot be reached here; treat it as an all-red clearance.
        phase_last = AR_LAST;
        phase_next = S_MG;
`endif
      end
    endcase

    if (tick) begin
      if (timed) begin
        if (cnt_q == phase_last) state_d = phase_next;
        else                     cnt_d   = cnt_q + CNT_ONE;
      end else if (state_q == S_MG) begin
        // Main green counter saturates; requests are honoured only once there.
        if (cnt_q != MG_LAST) cnt_d = cnt_q + CNT_ONE;
`ifdef NIGHT_MODE_EN
        else if (night) state_d = S_NIGHT;
`endif
        else if (side_pend_q || walk_pend_q) state_d = S_MY;
      end
`ifdef NIGHT_MODE_EN
      else if (!night) begin
        state_d = S_AR2;
      end
`endif
    end

    if (state_d != state_q) cnt_d = '0;
  end

  // Request latches: a clear on phase entry beats a same-clock set.
  always_comb begin
    side_pend_d = side_pend_q | side_req;
    walk_pend_d = walk_pend_q | walk_req;
    if (state_d == S_SG   && state_q != S_SG)   side_pend_d = 1'b0;
    if (state_d == S_WALK && state_q != S_WALK) walk_pend_d = 1'b0;
`ifdef NIGHT_MODE_EN
    if (state_d == S_NIGHT) begin
      side_pend_d = 1'b0;
      walk_pend_d = 1'b0;
    end
`endif
  end

`ifdef NIGHT_MODE_EN
  // Flash phase restarts on yellow each time night mode is entered.
  always_comb begin
    flash_d = flash_q;
    if (state_q == S_NIGHT && tick) flash_d = ~flash_q;
    if (state_d == S_NIGHT && state_q != S_NIGHT) flash_d = 1'b0;
  end
`endif

  // Lamp decode depends only on registered state.
  always_comb begin
    case (state_q)
      S_MG:    LEDs = 7'h18;
      S_MY:    LEDs = 7'h28;
      S_AR1:   LEDs = 7'h48;
      S_WALK:  LEDs = 7'h49;
      S_SG:    LEDs = 7'h42;
      S_SY:    LEDs = 7'h44;
      S_AR2:   LEDs = 7'h48;
`ifdef NIGHT_MODE_EN
      default: LEDs = flash_q ? 7'h00 : 7'h24;
`else
      default: LEDs = 7'h48;
`endif
    endcase
  end

  assign state = state_q;

endmodule
